command_encoder: RTL



---
 rtl/command_encoder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/command_encoder.sv
// Serialises one opcode+payload command into the receiver's byte stream and
// checks the receiver's byte echo against a small FIFO of sent bytes.
module command_encoder #(
  parameter int unsigned MAX_PAYLOAD_BYTES = 64,
  parameter int unsigned TRI_BYTES         = 36,
  parameter int unsigned SCENE_BYTES       = 40,
  parameter int unsigned XFORM_BYTES       = 48,
  parameter int unsigned ECHO_DEPTH        = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_s_valid,
  output logic                           req_s_ready,
  input  logic [7:0]                     req_s_opcode,
  input  logic [8*MAX_PAYLOAD_BYTES-1:0] req_s_payload,
  output logic                           cmd_m_valid,
  input  logic                           cmd_m_ready,
  output logic [7:0]                     cmd_m_data,
  input  logic                           echo_s_valid,
  input  logic [7:0]                     echo_s_data,
  output logic                           busy,
  output logic                           err_opcode,
  output logic                           echo_mismatch,
  output logic [15:0]                    mismatch_count
);

  localparam int unsigned LenW = $clog2(MAX_PAYLOAD_BYTES + 1);
  localparam int unsigned IdxW = (MAX_PAYLOAD_BYTES > 1) ? $clog2(MAX_PAYLOAD_BYTES) : 1;
  localparam int unsigned PtrW = $clog2(ECHO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StSendOp, StSendPay} state_e;

  state_e                         state_q, state_d;
  logic [8*MAX_PAYLOAD_BYTES-1:0] payload_q, payload_d;
  logic [LenW-1:0]                bytes_left_q, bytes_left_d;
  logic [7:0]                     data_q, data_d;
  logic                           err_q, err_d;

  logic [7:0]      fifo_mem_q [ECHO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] fifo_cnt_q;
  logic            fifo_full, fifo_empty, push, pop;
  logic            mm_q, mm_d;
  logic [15:0]     mcount_q;

  logic [LenW-1:0] req_len;
  logic            req_known;
  logic [LenW-1:0] sel_len;
  logic [IdxW-1:0] sel_idx;
  logic [7:0]      pay_sel;
  logic            hs;

  always_comb begin
    req_len   = '0;
    req_known = 1'b1;
    case (req_s_opcode)
      8'h55, 8'hA0: req_len = LenW'(1);
      8'hA1:        req_len = LenW'(TRI_BYTES);
      8'hB0:        req_len = LenW'(SCENE_BYTES);
      8'hC0:        req_len = LenW'(XFORM_BYTES);
      default:      req_known = 1'b0;
    endcase
  end

  assign fifo_full   = (fifo_cnt_q == CntW'(ECHO_DEPTH));
  assign fifo_empty  = (fifo_cnt_q == '0);
  // A full echo FIFO holds the pending byte back until the receiver catches up.
  assign cmd_m_valid = (state_q != StIdle) && !fifo_full;
  assign hs          = cmd_m_valid && cmd_m_ready;
  assign push        = hs;
  assign pop         = echo_s_valid && !fifo_empty;

  // Index of the byte to load after the current handshake (MSB first).
  assign sel_len = (state_q == StSendOp) ? bytes_left_q - LenW'(1) : bytes_left_q - LenW'(2);
  assign sel_idx = sel_len[IdxW-1:0];
  assign pay_sel = payload_q[{sel_idx, 3'b000} +: 8];

  always_comb begin
    state_d      = state_q;
    payload_d    = payload_q;
    bytes_left_d = bytes_left_q;
    data_d       = data_q;
    err_d        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_s_valid) begin
          if (req_known) begin
            state_d      = StSendOp;
            bytes_left_d = req_len;
            data_d       = req_s_opcode;
            payload_d    = req_s_payload;
            if (req_s_opcode == 8'h55) begin
              payload_d      = '0;
              payload_d[7:0] = 8'h55;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSendOp: begin
        if (hs) begin
          state_d = StSendPay;
          data_d  = pay_sel;
        end
      end
      StSendPay: begin
        if (hs) begin
          bytes_left_d = bytes_left_q - LenW'(1);
          if (bytes_left_q == LenW'(1)) begin
            state_d = StIdle;
          end else begin
            data_d = pay_sel;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      payload_q    <= '0;
      bytes_left_q <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      payload_q    <= payload_d;
      bytes_left_q <= bytes_left_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end

  // An echo with nothing outstanding also counts as a mismatch.
  assign mm_d = echo_s_valid && (fifo_empty || (fifo_mem_q[rd_ptr_q] != echo_s_data));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      mm_q       <= 1'b0;
      mcount_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      mm_q <= mm_d;
      if (mm_d && (mcount_q != 16'hFFFF)) begin
        mcount_q <= mcount_q + 16'd1;
      end
    end
  end

  assign req_s_ready    = (state_q == StIdle);
  assign busy           = (state_q != StIdle);
  assign cmd_m_data     = data_q;
  assign err_opcode     = err_q;
  assign echo_mismatch  = mm_q;
  assign mismatch_count = mcount_q;

endmodule
